// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one open-drain I2C bus between NUM_REQ bit-level masters.
// A watchdog revokes stuck tenures, then clocks out 9 SCL recovery pulses and a STOP.
module i2c_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int GAP_CYCLES     = 250,
  parameter int RECOVER_HALF   = 250,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  input  logic [NUM_REQ-1:0] scl_oe_req,
  input  logic [NUM_REQ-1:0] sda_oe_req,
  output logic [NUM_REQ-1:0] grant,
  output logic               scl_oe,
  output logic               sda_oe,
  output logic               busy,
  output logic               timeout_stb,
  output logic [2:0]         timeout_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, GRANT, GAP, RECOVER, STOP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   timer, timer_nxt, timer_inc;
  logic [IDX_W-1:0]   last_grant, last_grant_nxt;
  logic [NUM_REQ-1:0] grant_nxt, blocked, blocked_nxt, eligible;
  logic [3:0]         step, step_nxt;   // pulse count in RECOVER, phase in STOP
  logic               half, half_nxt;   // 0: SCL held low, 1: SCL released
  logic               timeout_stb_nxt;
  logic [2:0]         timeout_id_nxt;
  logic [IDX_W-1:0]   sel, sel_hi, sel_lo;
  logic               sel_vld, hi_vld;
  logic               half_end;

  assign eligible  = req & ~blocked;
  assign timer_inc = (timer == {CNT_W{1'b1}}) ? timer : timer + CNT_W'(1);
  assign half_end  = (timer == CNT_W'(RECOVER_HALF - 1));
  assign busy      = (state != IDLE);

  // Round-robin pick: lowest eligible index above last_grant, else lowest overall.
  always_comb begin
    sel_hi  = '0;
    sel_lo  = '0;
    hi_vld  = 1'b0;
    sel_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_lo  = IDX_W'(i);
        sel_vld = 1'b1;
        if (i > int'(last_grant)) begin
          sel_hi = IDX_W'(i);
          hi_vld = 1'b1;
        end
      end
    end
    sel = hi_vld ? sel_hi : sel_lo;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt       = state;
    timer_nxt       = timer_inc;
    grant_nxt       = grant;
    last_grant_nxt  = last_grant;
    blocked_nxt     = blocked & req;
    step_nxt        = step;
    half_nxt        = half;
    timeout_stb_nxt = 1'b0;
    timeout_id_nxt  = timeout_id;
    scl_oe          = 1'b0;
    sda_oe          = 1'b0;

    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (sel_vld) begin
          grant_nxt      = NUM_REQ'(1) << sel;
          last_grant_nxt = sel;
          state_nxt      = GRANT;
        end
      end

      GRANT: begin
        scl_oe = scl_oe_req[last_grant];
        sda_oe = sda_oe_req[last_grant];
        if (done[last_grant] || !req[last_grant]) begin
          grant_nxt = '0;
          timer_nxt = '0;
          state_nxt = GAP;
        end else if (timer == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          grant_nxt               = '0;
          timer_nxt               = '0;
          timeout_stb_nxt         = 1'b1;
          timeout_id_nxt          = 3'(last_grant);
          blocked_nxt[last_grant] = 1'b1;
          step_nxt                = '0;
          half_nxt                = 1'b0;
          state_nxt               = RECOVER;
        end
      end

      GAP: begin
        if (timer == CNT_W'(GAP_CYCLES - 1)) begin
          timer_nxt = '0;
          state_nxt = IDLE;
        end
      end

      RECOVER: begin
        scl_oe = !half;
        if (half_end) begin
          timer_nxt = '0;
          half_nxt  = !half;
          if (half) begin
            if (step == 4'd8) begin
              step_nxt  = '0;
              state_nxt = STOP;
            end else begin
              step_nxt = step + 4'd1;
            end
          end
        end
      end

      STOP: begin
        // SDA rises while SCL is released: a STOP condition on the wire.
        scl_oe = (step == 4'd0);
        sda_oe = (step != 4'd2);
        if (half_end) begin
          timer_nxt = '0;
          if (step == 4'd2) begin
            step_nxt  = '0;
            state_nxt = GAP;
          end else begin
            step_nxt = step + 4'd1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      grant       <= '0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      blocked     <= '0;
      step        <= '0;
      half        <= 1'b0;
      timeout_stb <= 1'b0;
      timeout_id  <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      grant       <= grant_nxt;
      last_grant  <= last_grant_nxt;
      blocked     <= blocked_nxt;
      step        <= step_nxt;
      half        <= half_nxt;
      timeout_stb <= timeout_stb_nxt;
      timeout_id  <= timeout_id_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: a tenure/timeline model queues the expected
// per-cycle outputs and an independent monitor compares them against the DUT.
module tb_i2c_bus_arbiter;

  localparam int NUM_REQ        = 2;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int GAP_CYCLES     = 4;
  localparam int RECOVER_HALF   = 2;
  localparam int CNT_W          = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, done, scl_oe_req, sda_oe_req;
  logic [1:0] grant;
  logic       scl_oe, sda_oe, busy, timeout_stb;
  logic [2:0] timeout_id;

  i2c_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .GAP_CYCLES(GAP_CYCLES),
    .RECOVER_HALF(RECOVER_HALF), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .scl_oe_req(scl_oe_req), .sda_oe_req(sda_oe_req),
    .grant(grant), .scl_oe(scl_oe), .sda_oe(sda_oe), .busy(busy),
    .timeout_stb(timeout_stb), .timeout_id(timeout_id)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int         cyc;
    logic [1:0] grant;
    logic       scl, sda, busy, stb;
    logic [2:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model: who owns the bus, when the tenure began, and a timeline of
  // expected {scl,sda} values for the bus-free / recovery cycles still to come.
  int         m_owner;
  int         m_gcyc;
  int         m_last;
  logic [1:0] m_blocked;
  logic       m_stb_pend;
  logic [2:0] m_toid;
  logic [1:0] post_q[$];

  function automatic logic bit_of(logic [1:0] v, int i);
    logic [1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [1:0] onehot(int i);
    logic [1:0] v;
    v = 2'b01 << i;
    return v;
  endfunction

  task automatic model_reset();
    m_owner    = -1;
    m_gcyc     = 0;
    m_last     = NUM_REQ - 1;
    m_blocked  = '0;
    m_stb_pend = 1'b0;
    m_toid     = '0;
    post_q.delete();
  endtask

  task automatic push_recovery();
    for (int p = 0; p < 9; p++) begin
      repeat (RECOVER_HALF) post_q.push_back(2'b10);
      repeat (RECOVER_HALF) post_q.push_back(2'b00);
    end
    repeat (RECOVER_HALF) post_q.push_back(2'b11);
    repeat (RECOVER_HALF) post_q.push_back(2'b01);
    repeat (RECOVER_HALF) post_q.push_back(2'b00);
    repeat (GAP_CYCLES) post_q.push_back(2'b00);
  endtask

  task automatic model_cycle();
    exp_t       e;
    logic [1:0] pair;
    int         sel;
    e.cyc   = cyc_cnt;
    e.grant = (m_owner >= 0) ? onehot(m_owner) : 2'b00;
    e.busy  = (m_owner >= 0) || (post_q.size() > 0);
    e.stb   = m_stb_pend;
    e.id    = m_toid;
    if (m_owner >= 0)          pair = {bit_of(scl_oe_req, m_owner), bit_of(sda_oe_req, m_owner)};
    else if (post_q.size() > 0) pair = post_q[0];
    else                        pair = 2'b00;
    e.scl = pair[1];
    e.sda = pair[0];
    exp_q.push_back(e);

    m_stb_pend = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    if (m_owner >= 0) begin
      if (bit_of(done, m_owner) || !bit_of(req, m_owner)) begin
        m_owner = -1;
        repeat (GAP_CYCLES) post_q.push_back(2'b00);
      end else if (cyc_cnt - m_gcyc == TIMEOUT_CYCLES - 1) begin
        m_stb_pend = 1'b1;
        m_toid     = 3'(m_owner);
        m_blocked  = m_blocked | onehot(m_owner);
        push_recovery();
        m_owner    = -1;
      end
    end else if (post_q.size() > 0) begin
      pair = post_q.pop_front();
    end else begin
      sel = -1;
      for (int k = NUM_REQ; k >= 1; k--)
        if (bit_of(req & ~m_blocked, (m_last + k) % NUM_REQ)) sel = (m_last + k) % NUM_REQ;
      if (sel >= 0) begin
        m_owner = sel;
        m_last  = sel;
        m_gcyc  = cyc_cnt + 1;
      end
    end
    m_blocked = m_blocked & req;
  endtask

  // ---------------- monitor ----------------
  function automatic bit diff(string nm, int cyc, logic [31:0] act, logic [31:0] expv);
    if (act !== expv) begin
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, expv);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check(input exp_t e);
    bit bad;
    checks++;
    bad = diff("cycle_sync", cyc_cnt, 32'(cyc_cnt), 32'(e.cyc))
        | diff("grant", cyc_cnt, 32'(grant), 32'(e.grant))
        | diff("scl_oe", cyc_cnt, 32'(scl_oe), 32'(e.scl))
        | diff("sda_oe", cyc_cnt, 32'(sda_oe), 32'(e.sda))
        | diff("busy", cyc_cnt, 32'(busy), 32'(e.busy))
        | diff("timeout_stb", cyc_cnt, 32'(timeout_stb), 32'(e.stb))
        | diff("timeout_id", cyc_cnt, 32'(timeout_id), 32'(e.id));
    if (bad) fails++;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rand_bus();
    scl_oe_req = 2'($urandom);
    sda_oe_req = 2'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (m_owner >= 0 || post_q.size() > 0); i++) begin
      rand_bus();
      tick();
    end
  endtask

  task automatic wait_age(input int age);
    for (int i = 0; i < 300 && m_owner >= 0 && (cyc_cnt - m_gcyc) < age; i++) begin
      rand_bus();
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; done = '0; scl_oe_req = '0; sda_oe_req = '0;
    model_reset();
    @(posedge clk);
    #1;
    ticks(3);
    reset = 1'b0;
    ticks(2);

    // Single request with random tenure length and pad drive patterns.
    req = 2'b01;
    tick();
    for (int i = 0; i < 3 + int'($urandom_range(0, 6)); i++) begin
      rand_bus();
      tick();
    end
    done = 2'b01; rand_bus(); tick(); done = '0;
    req = '0;
    ticks(8);

    // Contention: both held, owner releases after 5 cycles; non-owner done is noise.
    req = 2'b11;
    for (int i = 0; i < 70; i++) begin
      rand_bus();
      if (m_owner >= 0) begin
        done = 2'($urandom) & ~onehot(m_owner);
        if (cyc_cnt - m_gcyc >= 5) done = done | onehot(m_owner);
      end else begin
        done = 2'($urandom);
      end
      tick();
    end
    done = '0; req = '0;
    wait_idle();

    // Random request/done traffic.
    for (int i = 0; i < 400; i++) begin
      rand_bus();
      if ($urandom_range(0, 15) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 15) == 0) req[1] = ~req[1];
      done = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      tick();
    end
    done = '0; req = '0;
    wait_idle();
    ticks(2);

    // Timeout of master 1: recovery, STOP, gap, then no regrant while req held.
    req = 2'b10;
    for (int i = 0; i < TIMEOUT_CYCLES + 70; i++) begin
      rand_bus();
      tick();
    end
    req = 2'b00; tick();
    req = 2'b10; ticks(6);
    done = 2'b10; tick(); done = '0;
    req = '0;
    wait_idle();
    ticks(2);

    // Release coincides with the last tenure cycle: release wins.
    req = 2'b01;
    tick();
    wait_age(TIMEOUT_CYCLES - 1);
    done = 2'b01; tick(); done = '0;
    req = '0;
    wait_idle();
    ticks(2);

    // Reset during the 4th recovery pulse, then contention restarts at master 0.
    req = 2'b01;
    tick();
    for (int i = 0; i < 300 && !m_stb_pend; i++) begin
      rand_bus();
      tick();
    end
    ticks(13);
    reset = 1'b1; tick(); reset = 1'b0;
    req = 2'b11;
    ticks(4);
    done = 2'b01; tick(); done = '0;
    ticks(10);
    req = '0;
    wait_idle();
    ticks(3);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: actual=%0d pending expected=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
